// File: rtl/dmem_lsu_if.sv
`default_nettype none
// ============================================================================
// Module   : dmem_lsu_if
// Brief    : Core-side request/response channel of the load/store initiator.
// Revision : 1.0 - initial release
// ============================================================================
interface dmem_lsu_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_op;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    // master = execute stage issuing requests, slave = the load/store unit
    modport master (
        output req_valid, req_we, req_op, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_op, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface
`default_nettype wire

// File: rtl/dmem_lsu.sv
`default_nettype none
// ============================================================================
// Module   : dmem_lsu
// Brief    : One-at-a-time load/store initiator for a 4-lane byte memory with
//            registered read data. Optional macro: MISALIGN_TRAP_EN.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_lsu #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    dmem_lsu_if.slave         bus,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_we,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_CAPTURE = 2'd2,
        S_RESP    = 2'd3
    } state_t;

    state_t            r_state;
    logic              r_we;
    logic [2:0]        r_op;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic              r_rsp_valid;
    logic [31:0]       r_rsp_rdata;
    logic              r_rsp_err;

    logic              w_misalign;
    logic [3:0]        w_lane_we;
    logic [31:0]       w_lane_wdata;
    logic [7:0]        w_ld_byte;
    logic [15:0]       w_ld_half;
    logic              w_ld_sext;
    logic [31:0]       w_ld_data;

`ifdef MISALIGN_TRAP_EN
    assign w_misalign = (bus.req_op[1:0] == 2'b00) ? 1'b0 :
                        (bus.req_op[1:0] == 2'b01) ? bus.req_addr[0] :
                                                     (bus.req_addr[1:0] != 2'b00);
`else
    assign w_misalign = 1'b0;
`endif

    // Store lane selection from the latched request; word ignores addr[1:0]
    always_comb begin
        w_lane_we    = 4'b1111;
        w_lane_wdata = r_wdata;
        case (r_op[1:0])
            2'b00: begin
                w_lane_we    = 4'b0001 << r_addr[1:0];
                w_lane_wdata = {4{r_wdata[7:0]}};
            end
            2'b01: begin
                w_lane_we    = r_addr[1] ? 4'b1100 : 4'b0011;
                w_lane_wdata = {2{r_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        w_ld_byte = mem_rdata[7:0];
        case (r_addr[1:0])
            2'd0: w_ld_byte = mem_rdata[7:0];
            2'd1: w_ld_byte = mem_rdata[15:8];
            2'd2: w_ld_byte = mem_rdata[23:16];
            2'd3: w_ld_byte = mem_rdata[31:24];
            default: ;
        endcase
        w_ld_half = r_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        w_ld_sext = ~r_op[2];
        case (r_op[1:0])
            2'b00:   w_ld_data = {{24{w_ld_sext & w_ld_byte[7]}}, w_ld_byte};
            2'b01:   w_ld_data = {{16{w_ld_sext & w_ld_half[15]}}, w_ld_half};
            default: w_ld_data = mem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_we        <= 1'b0;
            r_op        <= 3'd0;
            r_addr      <= '0;
            r_wdata     <= 32'd0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'd0;
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        r_we    <= bus.req_we;
                        r_op    <= bus.req_op;
                        r_addr  <= bus.req_addr;
                        r_wdata <= bus.req_wdata;
                        if (w_misalign) begin
                            // Trapped access never touches memory
                            r_state     <= S_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_rdata <= 32'd0;
                            r_rsp_err   <= 1'b1;
                        end else begin
                            r_state   <= S_ISSUE;
                            r_rsp_err <= 1'b0;
                        end
                    end
                end
                S_ISSUE: begin
                    if (r_we) begin
                        r_state     <= S_RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= 32'd0;
                    end else begin
                        r_state <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    r_state     <= S_RESP;
                    r_rsp_valid <= 1'b1;
                    r_rsp_rdata <= w_ld_data;
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        r_state     <= S_IDLE;
                        r_rsp_valid <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // rst gates the write strobe directly so a store caught mid-ISSUE is dropped
    assign mem_we    = (r_state == S_ISSUE && r_we && !rst) ? w_lane_we : 4'b0000;
    assign mem_wdata = w_lane_wdata;
    assign mem_addr  = r_addr;

    assign bus.req_ready = (r_state == S_IDLE);
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_err   = r_rsp_err;

endmodule
`default_nettype wire
